// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcode/funct7 constants and the decoded-beat
// record handed from decode to execute.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_ALI    = 7'b0010011;
  localparam logic [6:0] OPC_ALU    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
  } decoded_t;

  localparam int unsigned DEC_W = $bits(decoded_t);

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/instr_field_dec.sv
// Combinational RV32I field / immediate / legality / register-usage decoder.
module instr_field_dec
  import decode_pkg::*;
#(
  parameter int unsigned M_EXT = 0
) (
  input  logic [31:0]      i_instr,
  output logic [DEC_W-1:0] o_dec
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm;
  logic        w_ill;
  logic        w_ur1;
  logic        w_ur2;
  logic        w_wrd;
  decoded_t    w_dec;

  assign w_opc   = i_instr[6:0];
  assign w_f3    = i_instr[14:12];
  assign w_f7    = i_instr[31:25];
  assign w_imm_i = sext12(i_instr[31:20]);
  assign w_imm_s = sext12({i_instr[31:25], i_instr[11:7]});
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};

  // Per-opcode immediate, legality and raw usage flags; illegal beats and rd=x0
  // then mask the flags so the hazard unit never sees a phantom dependency.
  always_comb begin
    w_imm = '0;
    w_ill = 1'b0;
    w_ur1 = 1'b0;
    w_ur2 = 1'b0;
    w_wrd = 1'b0;
    case (w_opc)
      OPC_LOAD: begin
        w_imm = w_imm_i;
        w_ur1 = 1'b1;
        w_wrd = 1'b1;
        w_ill = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
      end
      OPC_STORE: begin
        w_imm = w_imm_s;
        w_ur1 = 1'b1;
        w_ur2 = 1'b1;
        w_ill = (w_f3 > 3'd2);
      end
      OPC_BRANCH: begin
        w_imm = w_imm_b;
        w_ur1 = 1'b1;
        w_ur2 = 1'b1;
        w_ill = (w_f3 == 3'd2) || (w_f3 == 3'd3);
      end
      OPC_JAL: begin
        w_imm = w_imm_j;
        w_wrd = 1'b1;
      end
      OPC_JALR: begin
        w_imm = w_imm_i;
        w_ur1 = 1'b1;
        w_wrd = 1'b1;
        w_ill = (w_f3 != 3'd0);
      end
      OPC_LUI, OPC_AUIPC: begin
        w_imm = w_imm_u;
        w_wrd = 1'b1;
      end
      OPC_ALI: begin
        w_imm = w_imm_i;
        w_ur1 = 1'b1;
        w_wrd = 1'b1;
        w_ill = ((w_f3 == 3'd1) && (w_f7 != F7_BASE)) ||
                ((w_f3 == 3'd5) && (w_f7 != F7_BASE) && (w_f7 != F7_ALT));
      end
      OPC_ALU: begin
        w_ur1 = 1'b1;
        w_ur2 = 1'b1;
        w_wrd = 1'b1;
        if (w_f7 == F7_BASE)        w_ill = 1'b0;
        else if (w_f7 == F7_ALT)    w_ill = (w_f3 != 3'd0) && (w_f3 != 3'd5);
        else if (w_f7 == F7_MULDIV) w_ill = (M_EXT == 0);
        else                        w_ill = 1'b1;
      end
      OPC_FENCE: begin
      end
      OPC_SYSTEM: begin
        w_ur1 = (w_f3 == 3'd1) || (w_f3 == 3'd2) || (w_f3 == 3'd3);
        w_wrd = (w_f3 != 3'd0);
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_ur1 = 1'b0;
      w_ur2 = 1'b0;
      w_wrd = 1'b0;
    end
    if (i_instr[11:7] == 5'd0) w_wrd = 1'b0;
  end

  // Pack the decoded record.
  always_comb begin
    w_dec           = '0;
    w_dec.opcode    = w_opc;
    w_dec.funct3    = w_f3;
    w_dec.funct7    = w_f7;
    w_dec.rs1       = i_instr[19:15];
    w_dec.rs2       = i_instr[24:20];
    w_dec.rd        = i_instr[11:7];
    w_dec.imm       = w_imm;
    w_dec.illegal   = w_ill;
    w_dec.uses_rs1  = w_ur1;
    w_dec.uses_rs2  = w_ur2;
    w_dec.writes_rd = w_wrd;
  end

  assign o_dec = w_dec;

endmodule

// File: rtl/id_stage.sv
// Registered RV32I decode stage with valid/ready handshake, optional skid
// buffer and flush.
module id_stage
  import decode_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned M_EXT = 0,
  parameter int unsigned SKID  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal,
  output logic            out_uses_rs1,
  output logic            out_uses_rs2,
  output logic            out_writes_rd
);

  logic [DEC_W-1:0] w_dec_bits;
  decoded_t         w_dec;
  logic             w_push;
  logic             w_pop;

  decoded_t         r_main_beat;
  logic [PC_W-1:0]  r_main_pc;
  logic             r_main_valid;
  decoded_t         r_skid_beat;
  logic [PC_W-1:0]  r_skid_pc;
  logic             r_skid_valid;

  instr_field_dec #(.M_EXT(M_EXT)) u_dec (
    .i_instr (in_instr),
    .o_dec   (w_dec_bits)
  );

  assign w_dec    = w_dec_bits;
  // With SKID=0 the skid register can never fill, because in_ready already
  // requires the main register to be free or draining.
  assign in_ready = (SKID != 0) ? !r_skid_valid : (!r_main_valid || out_ready);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = r_main_valid && out_ready;

  // Main/skid registers: flush and reset drop everything; skid drains first so
  // beat order is preserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_beat  <= '0;
      r_main_pc    <= '0;
      r_main_valid <= 1'b0;
      r_skid_beat  <= '0;
      r_skid_pc    <= '0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      if (w_pop) begin
        r_main_beat  <= r_skid_beat;
        r_main_pc    <= r_skid_pc;
        r_skid_valid <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_main_valid || w_pop) begin
        r_main_beat  <= w_dec;
        r_main_pc    <= in_pc;
        r_main_valid <= 1'b1;
      end else begin
        r_skid_beat  <= w_dec;
        r_skid_pc    <= in_pc;
        r_skid_valid <= 1'b1;
      end
    end else if (w_pop) begin
      r_main_valid <= 1'b0;
    end
  end

  assign out_valid     = r_main_valid;
  assign out_opcode    = r_main_beat.opcode;
  assign out_funct3    = r_main_beat.funct3;
  assign out_funct7    = r_main_beat.funct7;
  assign out_rs1       = r_main_beat.rs1;
  assign out_rs2       = r_main_beat.rs2;
  assign out_rd        = r_main_beat.rd;
  assign out_imm       = r_main_beat.imm;
  assign out_pc        = r_main_pc;
  assign out_illegal   = r_main_beat.illegal;
  assign out_uses_rs1  = r_main_beat.uses_rs1;
  assign out_uses_rs2  = r_main_beat.uses_rs2;
  assign out_writes_rd = r_main_beat.writes_rd;

endmodule

// File: doc/id_stage.md
# id_stage

Registered RV32I instruction-decode pipeline stage with a valid/ready handshake on both sides, sitting between fetch and execute. It is the parametrised successor of the combinational field/immediate decoder. It adds an optional two-entry skid buffer, a flush input, and illegal-instruction detection with optional M-extension acceptance. It also produces register-usage flags for the hazard unit.

## Interface
- PC_W, 32, width of the program-counter sideband.
- M_EXT, 0, 1: OPC_ALU with funct7=0000001 is legal; 0: it is illegal.
- SKID, 1, 1: two-entry buffer with registered in_ready; 0: single register, in_ready = !out_valid | out_ready.
- Clock and reset are decided: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming beats.
- in_valid  in  1  fetch beat valid.
- in_ready  out  1  stage can accept a beat.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction address.
- out_valid  out  1  decoded beat valid.
- out_ready  in  1  execute accepts the beat.
- out_opcode / out_funct3 / out_funct7  out  7/3/7  instruction fields [6:0], [14:12], [31:25].
- out_rs1 / out_rs2 / out_rd  out  5/5/5  register fields [19:15], [24:20], [11:7].
- out_imm  out  32  sign-extended immediate.
- out_pc  out  PC_W  in_pc of the beat.
- out_illegal  out  1  beat is an illegal instruction.
- out_uses_rs1 / out_uses_rs2 / out_writes_rd  out  1 each  hazard flags.

## Operation
- Beat transfer occurs on valid & ready, on either side.
- Immediate formats:
  - I: LOAD, ALI, JALR.
  - S: STORE.
  - B: BRANCH, bit 0 = 0.
  - J: JAL, bit 0 = 0.
  - U: LUI and AUIPC, {instr[31:12], 12'b0}.
  - Any other opcode gives 0.
- The instruction is illegal when any of the following holds:
  - instr[1:0] != 2'b11, or the opcode is not one of LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, ALI, ALU, FENCE, SYSTEM.
  - LOAD funct3 ∈ {3,6,7}; STORE funct3 > 2; BRANCH funct3 ∈ {2,3}; JALR funct3 != 0.
  - ALI: for funct3=1, funct7 != 0; for funct3=5, funct7 ∉ {0000000, 0100000}.
  - ALU: funct7=0100000 with funct3 ∉ {0,5}.
  - ALU: any other funct7 except 0000000, or 0000001 when M_EXT=1.
- An illegal beat still flows through the stage with out_illegal=1, out_writes_rd=0, out_uses_rs1=0 and out_uses_rs2=0.
- out_uses_rs1 = 1 for LOAD, STORE, BRANCH, JALR, ALI, ALU, and for SYSTEM with funct3 ∈ {1,2,3}.
- out_uses_rs2 = 1 for STORE, BRANCH, ALU.
- out_writes_rd = 1 only for LUI, AUIPC, JAL, JALR, LOAD, ALI, ALU, and SYSTEM with funct3 != 0, and only when rd != 0.
- SKID=1 buffer behaviour:
  - The main register drives the outputs.
  - A beat accepted while the main register is full and stalled (out_ready=0) goes to the skid register; in_ready drops the following cycle.
  - When the main register drains, the skid content moves into it and in_ready rises.
  - Order is always preserved.

## Timing
- Latency: exactly 1 cycle from accept to out_valid; decode is combinational on the input side and registered.
- Throughput: one beat per cycle when out_ready=1.
- Reset: out_valid=0, skid empty, in_ready=1 (both modes since out_valid=0), all data outputs 0.
- Reset mid-operation discards every held beat.
- flush: out_valid=0 and skid empty on the next cycle, and in_ready=1.
  - flush beats a simultaneous input transfer; that beat is dropped.
  - flush beats a simultaneous output transfer; execute ignores out_* during a flush cycle.
- Simultaneous push and pop with the main register full and the skid empty: the new beat loads the main register and the skid stays empty.
- out_* stay stable while out_valid & !out_ready.

## Structure
- Shared package decode_pkg:
  - opcode constants (OPC_LOAD … OPC_SYSTEM, identical to DEFINE.vh values);
  - funct7 constants F7_BASE, F7_ALT, F7_MULDIV;
  - a packed decoded-beat struct shared with execute.
- One sub-module, instr_field_dec: purely combinational; it maps instr to fields, imm, illegal and the usage flags, and takes M_EXT as a parameter. id_stage holds only the handshake, the registers and the skid.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) with out_ready=1 → next cycle out_valid=1, out_imm=5, out_rd=1, out_writes_rd=1, out_illegal=0.
- BEQ x1,x2,-4 (0xFE208EE3) → out_imm=0xFFFFFFFC, out_uses_rs1=1, out_uses_rs2=1, out_writes_rd=0.
- MUL x3,x1,x2 (0x022081B3): with M_EXT=0 → out_illegal=1, out_writes_rd=0; with M_EXT=1 → out_illegal=0, out_writes_rd=1. Word 0x00000000 → out_illegal=1.
- SKID=1, out_ready=0, three back-to-back beats with PCs 0x0/0x4/0x8 → in_ready=0 after the second beat and the third is held upstream. Raising out_ready → out_pc sequence 0x0, 0x4, 0x8 with none lost or duplicated.
- Both entries full, flush=1 with in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, and the flushed PCs never appear.
- rst asserted while out_valid=1 and stalled → next cycle out_valid=0, out_imm=0, in_ready=1.
